// File: rtl/seg7_scan.sv
// Time-multiplexed 7-segment driver: shadows a packed hex value on load and
// scans one digit per prescaler slot, with decimal points, zero blanking and enable.
module seg7_scan #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned DIV        = 50000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic                  en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     ga
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CntMax = CW'(DIV - 1);
  localparam logic [IW-1:0] IdxMax = IW'(DIGITS - 1);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                tick;
  logic [4*DIGITS-1:0] sdata_q;
  logic [DIGITS-1:0]   sdp_q;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   ga_q, ga_d;
  logic [DIGITS-1:0]   lz;
  logic                allz;
  logic [3:0]          nib;
  logic                sdp_sel, blank_sel;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  always_comb begin
    tick  = (cnt_q == CntMax);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + IW'(1);
    end
  end

  // lz[i]: nibbles i..DIGITS-1 are all zero; digit 0 is never blanked.
  always_comb begin
    allz = 1'b1;
    lz   = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      allz  = allz & (sdata_q[4*i +: 4] == 4'h0);
      lz[i] = allz;
    end
    lz[0] = 1'b0;
  end

  always_comb begin
    nib       = '0;
    sdp_sel   = 1'b0;
    blank_sel = 1'b0;
    ga_d      = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IW'(i)) begin
        nib       = sdata_q[4*i +: 4];
        sdp_sel   = sdp_q[i];
        blank_sel = lz[i] & blank_lz;
        ga_d[i]   = 1'b1;
      end
    end
    seg_d = blank_sel ? 7'h00 : hex7(nib);
    dp_d  = sdp_sel;
    if (!en) begin
      ga_d  = '0;
      seg_d = 7'h00;
      dp_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      sdata_q <= '0;
      sdp_q   <= '0;
      seg_q   <= '0;
      dp_q    <= 1'b0;
      ga_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      if (load) begin
        sdata_q <= data;
        sdp_q   <= dp_in;
      end
      seg_q <= seg_d;
      dp_q  <= dp_d;
      ga_q  <= ga_d;
    end
  end

  assign seg = ACTIVE_LOW ? ~seg_q : seg_q;
  assign dp  = ACTIVE_LOW ? ~dp_q : dp_q;
  assign ga  = ACTIVE_LOW ? ~ga_q : ga_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan (DIGITS=4, DIV=4, active-high pins): glyph table vectors,
// hand-written corner sequences and random stimulus against a reference model.
module tb_seg7_scan;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic        en = 1'b1;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  ga;

  int n_chk  = 0;
  int n_fail = 0;

  seg7_scan #(.DIGITS(DIGITS), .DIV(DIV), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .load(load), .data(data), .dp_in(dp_in),
    .blank_lz(blank_lz), .en(en), .seg(seg), .dp(dp), .ga(ga)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state: integers following the behavioural rules.
  int m_cnt, m_idx, m_data, m_dp;
  bit m_valid = 0;
  int e_seg, e_dp, e_ga;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model computes outputs from pre-edge state, then advances.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      e_seg = 0; e_dp = 0; e_ga = 0;
      m_cnt = 0; m_idx = 0; m_data = 0; m_dp = 0;
      m_valid = 1;
    end else if (m_valid) begin
      if (!en) begin
        e_seg = 0; e_dp = 0; e_ga = 0;
      end else begin
        int n;
        bit blank;
        n = (m_data >> (4 * m_idx)) & 15;
        blank = blank_lz && m_idx > 0 && (m_data >> (4 * m_idx)) == 0;
        e_ga  = 1 << m_idx;
        e_seg = blank ? 0 : int'(glyph[n]);
        e_dp  = (m_dp >> m_idx) & 1;
      end
      if (m_cnt == DIV - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % DIGITS;
      end else begin
        m_cnt++;
      end
      if (load) begin
        m_data = int'(data);
        m_dp   = int'(dp_in);
      end
    end
    #1;
    if (m_valid) begin
      check("model_seg", int'(seg), e_seg);
      check("model_dp", int'(dp), e_dp);
      check("model_ga", int'(ga), e_ga);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    data = d; dp_in = p; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Bounded wait for a given digit slot, then compare its segment and dp.
  task automatic expect_slot(input string name, input int g, input int s, input int d);
    bit found = 0;
    for (int i = 0; i < 4 * DIV * DIGITS && !found; i++) begin
      step();
      if (int'(ga) == g) begin
        found = 1;
        check({name, "_seg"}, int'(seg), s);
        check({name, "_dp"}, int'(dp), d);
      end
    end
    if (!found) check({name, "_timeout"}, int'(ga), g);
  endtask

  typedef struct {
    logic [3:0] nib;
    logic [6:0] seg;
  } vec_t;

  vec_t vecs [16];

  initial begin
    vecs = '{'{4'h0, 7'h3F}, '{4'h1, 7'h06}, '{4'h2, 7'h5B}, '{4'h3, 7'h4F},
             '{4'h4, 7'h66}, '{4'h5, 7'h6D}, '{4'h6, 7'h7D}, '{4'h7, 7'h07},
             '{4'h8, 7'h7F}, '{4'h9, 7'h6F}, '{4'hA, 7'h77}, '{4'hB, 7'h7C},
             '{4'hC, 7'h39}, '{4'hD, 7'h5E}, '{4'hE, 7'h79}, '{4'hF, 7'h71}};

    // Reset and first slot timing
    rst = 1'b1;
    run(2);
    check("reset_ga", int'(ga), 0);
    check("reset_seg", int'(seg), 0);
    rst = 1'b0;
    step();
    check("first_ga", int'(ga), 1);
    run(3);
    check("slot0_hold", int'(ga), 1);
    step();
    check("slot1_start", int'(ga), 2);

    // Scan and decode
    do_load(16'h1234, 4'b0000);
    expect_slot("scan_d0", 1, 8'h66, 0);
    expect_slot("scan_d1", 2, 8'h4F, 0);
    expect_slot("scan_d2", 4, 8'h5B, 0);
    expect_slot("scan_d3", 8, 8'h06, 0);

    // Glyph sweep on digit 0
    for (int v = 0; v < 16; v++) begin
      do_load({12'h000, vecs[v].nib}, 4'b0001);
      expect_slot("glyph", 1, int'(vecs[v].seg), 1);
    end

    // Leading-zero blanking
    blank_lz = 1'b1;
    do_load(16'h0070, 4'b1000);
    expect_slot("blank_d3", 8, 0, 1);
    expect_slot("blank_d2", 4, 0, 0);
    expect_slot("blank_d1", 2, 8'h07, 0);
    expect_slot("blank_d0", 1, 8'h3F, 0);
    do_load(16'h0000, 4'b0000);
    expect_slot("zero_d2", 4, 0, 0);
    expect_slot("zero_d0", 1, 8'h3F, 0);
    blank_lz = 1'b0;

    // Load in the same cycle as tick
    for (int i = 0; i < 2 * DIV && m_cnt != DIV - 1; i++) step();
    check("tick_align", m_cnt, DIV - 1);
    do_load(16'h8888, 4'b0000);
    step();
    check("load_on_tick_seg", int'(seg), 8'h7F);

    // Enable drop keeps the scan phase
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("en_off_ga", int'(ga), 0);
    end
    en = 1'b1;
    run(2 * DIV);

    // Reset mid-scan
    for (int i = 0; i < 2 * DIV * DIGITS && m_idx != 2; i++) step();
    check("midscan_idx", m_idx, 2);
    rst = 1'b1;
    step();
    check("midscan_rst_ga", int'(ga), 0);
    rst = 1'b0;
    step();
    check("restart_ga", int'(ga), 1);
    check("restart_seg", int'(seg), 8'h3F);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      load     = ($urandom_range(0, 7) == 0);
      data     = 16'($urandom);
      if ($urandom_range(0, 2) == 0) data = data & 16'h00FF;
      if ($urandom_range(0, 3) == 0) data = data & 16'h000F;
      dp_in    = 4'($urandom);
      blank_lz = 1'($urandom);
      en       = ($urandom_range(0, 9) != 0);
      rst      = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; load = 1'b0; en = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
